// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, feeding the IF PC-select mux.
// Latency: lookup is combinational (zero cycles); training is visible the cycle after the edge.
// Backpressure: none; one lookup and one training update are accepted every cycle.
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int PC_W    = 12
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] lookup_pc,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic [31:0] nextPcBTB,
    output logic [1:0]  pcSrc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_jump
);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Entry storage; only valid and ctr are reset, tag/target are don't-care while invalid.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr;
    logic             wr_en;
    logic             wr_tgt;
    logic [1:0]       wr_ctr;

    // PC bits outside the index/tag window (and upper target bits) are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{lookup_pc[31:PC_W], lookup_pc[1:0],
                           upd_pc[31:PC_W], upd_pc[1:0], upd_target[31:PC_W]};

    // Fetch-side lookup: reads pre-edge contents, no bypass from a same-cycle update.
    always_comb begin
        l_idx      = lookup_pc[IDX_W+1:2];
        l_tag      = lookup_pc[PC_W-1:IDX_W+2];
        btb_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken = btb_hit && ctr_q[l_idx][1];
        nextPcBTB  = btb_hit ? {{(32-PC_W){1'b0}}, target_q[l_idx]} : 32'd0;
        pcSrc      = {btb_hit, pred_taken};
    end

    // Training decode: jumps force strongly-taken, branches move the counter one step,
    // and a not-taken branch that misses leaves any aliasing entry untouched.
    always_comb begin
        u_idx  = upd_pc[IDX_W+1:2];
        u_tag  = upd_pc[PC_W-1:IDX_W+2];
        u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_ctr  = ctr_q[u_idx];
        wr_en  = 1'b0;
        wr_tgt = 1'b0;
        wr_ctr = u_ctr;
        if (upd_is_jump) begin
            wr_en  = 1'b1;
            wr_tgt = 1'b1;
            wr_ctr = 2'b11;
        end else if (upd_taken) begin
            wr_en  = 1'b1;
            wr_tgt = 1'b1;
            if (!u_hit)
                wr_ctr = 2'b10;
            else if (u_ctr != 2'b11)
                wr_ctr = u_ctr + 2'd1;
        end else if (u_hit) begin
            wr_en = 1'b1;
            if (u_ctr != 2'b00)
                wr_ctr = u_ctr - 2'd1;
        end
    end

    // Entry update: reset wipes every entry and blocks training in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_valid && wr_en) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            ctr_q[u_idx]   <= wr_ctr;
            if (wr_tgt)
                target_q[u_idx] <= upd_target[PC_W-1:0];
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed lookups/trainings with hand-computed results.
// Stimulus pushes the expected lookup response; a negedge monitor pops and compares.
// Indices/tags used: 0x040 idx0 tag1, 0x440 idx0 tag17, 0x0C0 idx0 tag3, 0x084 idx1, 0x108 idx2, 0x20C idx3.
module tb_btb_predictor;
    logic        CLK;
    logic        RSTn;
    logic [31:0] lookup_pc;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] nextPcBTB;
    logic [1:0]  pcSrc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;

    btb_predictor dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .lookup_pc   (lookup_pc),
        .btb_hit     (btb_hit),
        .pred_taken  (pred_taken),
        .nextPcBTB   (nextPcBTB),
        .pcSrc       (pcSrc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_is_jump (upd_is_jump)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected response: {btb_hit, pred_taken, pcSrc, nextPcBTB}
    logic [35:0] exp_q  [$];
    string       name_q [$];
    logic        chk_vld;
    int          n_checks;
    int          n_fail;

    // Monitor: sample the combinational lookup mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (chk_vld) begin
            logic [35:0] act;
            logic [35:0] exp;
            string       nm;
            act = {btb_hit, pred_taken, pcSrc, nextPcBTB};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got %h, required an expected entry", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got hit=%b taken=%b pcSrc=%b next=%h, required hit=%b taken=%b pcSrc=%b next=%h",
                             nm, act[35], act[34], act[33:32], act[31:0],
                             exp[35], exp[34], exp[33:32], exp[31:0]);
                end
            end
        end
    end

    // One cycle of stimulus: optional checked lookup plus optional training update.
    task automatic drive(input logic [31:0] lpc, input logic chk, input logic ehit,
                         input logic etk, input logic [31:0] etgt, input string nm,
                         input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utk, input logic ujmp);
        lookup_pc   = lpc;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_target  = utgt;
        upd_taken   = utk;
        upd_is_jump = ujmp;
        chk_vld     = chk;
        if (chk) begin
            exp_q.push_back({ehit, etk, ehit, etk, ehit ? etgt : 32'd0});
            name_q.push_back(nm);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input logic [31:0] lpc, input logic ehit, input logic etk,
                        input logic [31:0] etgt, input string nm);
        drive(lpc, 1'b1, ehit, etk, etgt, nm, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic train(input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utk, input logic ujmp);
        drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, "", 1'b1, upc, utgt, utk, ujmp);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        chk_vld     = 1'b0;
        RSTn        = 1'b0;
        lookup_pc   = 32'h040;
        upd_valid   = 1'b0;
        upd_pc      = 32'd0;
        upd_target  = 32'd0;
        upd_taken   = 1'b0;
        upd_is_jump = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // T1: reset state reads as a miss
        look(32'h040, 1'b0, 1'b0, 32'h0, "t1_reset_miss");
        RSTn = 1'b1;

        // T2: taken branch allocates weakly-taken
        train(32'h040, 32'h100, 1'b1, 1'b0);
        look(32'h040, 1'b1, 1'b1, 32'h100, "t2_alloc_taken");

        // T3: counter walk-down with saturation at 00
        train(32'h040, 32'h3FC, 1'b0, 1'b0);
        look(32'h040, 1'b1, 1'b0, 32'h100, "t3_ctr01");
        train(32'h040, 32'h3FC, 1'b0, 1'b0);
        look(32'h040, 1'b1, 1'b0, 32'h100, "t3_ctr00");
        train(32'h040, 32'h3FC, 1'b0, 1'b0);
        look(32'h040, 1'b1, 1'b0, 32'h100, "t3_ctr00_sat");
        // walk-up: 00->01 stays not-taken only if the decrement did not wrap
        train(32'h040, 32'h100, 1'b1, 1'b0);
        look(32'h040, 1'b1, 1'b0, 32'h100, "t3_ctr01_up");
        train(32'h040, 32'h100, 1'b1, 1'b0);
        look(32'h040, 1'b1, 1'b1, 32'h100, "t3_ctr10_up");
        train(32'h040, 32'h100, 1'b1, 1'b0);
        look(32'h040, 1'b1, 1'b1, 32'h100, "t3_ctr11_up");
        // extra taken at 11 must stay 11; then one not-taken -> 10, still taken
        train(32'h040, 32'h104, 1'b1, 1'b0);
        look(32'h040, 1'b1, 1'b1, 32'h104, "t3_ctr11_sat_newtgt");
        train(32'h040, 32'h3FC, 1'b0, 1'b0);
        look(32'h040, 1'b1, 1'b1, 32'h104, "t3_no_wrap_tgt_kept");

        // T4: aliasing entry replaced by a JAL allocation
        look(32'h440, 1'b0, 1'b0, 32'h0, "t4_alias_miss");
        train(32'h440, 32'h200, 1'b1, 1'b1);
        look(32'h440, 1'b1, 1'b1, 32'h200, "t4_jal_alloc");
        look(32'h040, 1'b0, 1'b0, 32'h0, "t4_old_evicted");
        // not-taken branch that misses must not disturb the aliasing entry
        train(32'h040, 32'h300, 1'b0, 1'b0);
        look(32'h440, 1'b1, 1'b1, 32'h200, "t4_nt_miss_nowrite");
        look(32'h040, 1'b0, 1'b0, 32'h0, "t4_nt_miss_no_alloc");
        // hit jump forces the counter back to 11 and refreshes the target
        train(32'h440, 32'h3FC, 1'b0, 1'b0);
        train(32'h440, 32'h3FC, 1'b0, 1'b0);
        look(32'h440, 1'b1, 1'b0, 32'h200, "t4_ctr01");
        train(32'h440, 32'h208, 1'b1, 1'b1);
        look(32'h440, 1'b1, 1'b1, 32'h208, "t4_hit_jump_ctr11");

        // Upper/low PC bits ignored; target truncated to 12 bits
        train(32'h5000_0084, 32'hABCD_E9A0, 1'b1, 1'b1);
        look(32'h084, 1'b1, 1'b1, 32'h9A0, "trunc_target");
        look(32'h087, 1'b1, 1'b1, 32'h9A0, "low_bits_ignored");
        look(32'h7000_0084, 1'b1, 1'b1, 32'h9A0, "high_bits_ignored");

        // T5: same-cycle lookup and training show pre-edge contents
        drive(32'h0C0, 1'b1, 1'b0, 1'b0, 32'h0, "t5_same_cycle_miss",
              1'b1, 32'h0C0, 32'h150, 1'b1, 1'b0);
        drive(32'h0C0, 1'b1, 1'b1, 1'b1, 32'h150, "t5_same_cycle_old",
              1'b1, 32'h0C0, 32'h160, 1'b1, 1'b1);
        look(32'h0C0, 1'b1, 1'b1, 32'h160, "t5_next_cycle_new");

        // T6: fill, reset with a concurrent update, everything misses
        train(32'h108, 32'h010, 1'b1, 1'b1);
        look(32'h108, 1'b1, 1'b1, 32'h010, "t6_fill");
        RSTn = 1'b0;
        train(32'h20C, 32'h044, 1'b1, 1'b1);
        RSTn = 1'b1;
        look(32'h0C0, 1'b0, 1'b0, 32'h0, "t6_reset_idx0");
        look(32'h084, 1'b0, 1'b0, 32'h0, "t6_reset_idx1");
        look(32'h108, 1'b0, 1'b0, 32'h0, "t6_reset_idx2");
        look(32'h20C, 1'b0, 1'b0, 32'h0, "t6_upd_in_reset_dropped");

        chk_vld = 1'b0;
        repeat (2) @(posedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
